// File: rtl/reboot_trigger.sv
// rtl/reboot_trigger.sv - decides when the FPGA reconfigures via the ICAP reboot sequencer
//
// Purpose:
//   Collects reboot requests from three sources and releases the downstream
//   sequencer's hold line after a flush delay. The three sources are a 4-byte
//   magic command, a debounced push button and an optional watchdog. Once
//   released, the hold stays low until rst_n.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   cmd_valid  one-cycle strobe, cmd_data valid
//   cmd_data   received command byte
//   btn_n      raw asynchronous push button, active low
//   wdt_en     watchdog enable
//   wdt_kick   watchdog service pulse
//   reboot     sequencer hold: 1 = hold idle, 0 = run reboot
//   pending    reboot accepted; delay running or already fired
//   cause      0 none, 1 command, 2 button, 3 watchdog

module reboot_trigger #(
  parameter logic [31:0] MAGIC           = 32'h424F4F54,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          WDT_CYCLES      = 50000000,
  parameter int          DELAY_CYCLES    = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  input  logic       btn_n,
  input  logic       wdt_en,
  input  logic       wdt_kick,
  output logic       reboot,
  output logic       pending,
  output logic [1:0] cause
);

  // Counter widths. The debounce counter must hold DEBOUNCE_CYCLES itself
  // (saturation value); the watchdog only ever reaches WDT_CYCLES-1.
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WDT_W = $clog2(WDT_CYCLES);
  localparam int DLY_W = $clog2(DELAY_CYCLES + 1);

  localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]  DB_PRE   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WDT_W-1:0] WDT_TERM = WDT_W'(WDT_CYCLES - 1);
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(DELAY_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_FIRE  = 2'd2;

  localparam logic [1:0] CAUSE_CMD = 2'd1;
  localparam logic [1:0] CAUSE_BTN = 2'd2;
  localparam logic [1:0] CAUSE_WDT = 2'd3;

  // ---------------------------------------------------------------------------
  // Magic command matcher
  // ---------------------------------------------------------------------------
  logic [1:0] idx;
  logic [7:0] magic_byte;
  logic       byte_hit;
  logic       cmd_trig;

  // Byte 0 is the most significant byte of MAGIC.
  always_comb begin
    magic_byte = MAGIC[31:24];
    case (idx)
      2'd0: magic_byte = MAGIC[31:24];
      2'd1: magic_byte = MAGIC[23:16];
      2'd2: magic_byte = MAGIC[15:8];
      2'd3: magic_byte = MAGIC[7:0];
      default: magic_byte = MAGIC[31:24];
    endcase
  end

  assign byte_hit = (cmd_data == magic_byte);
  assign cmd_trig = cmd_valid && byte_hit && (idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= 2'd0;
    end else if (cmd_valid) begin
      if (byte_hit) begin
        // idx wraps 3 -> 0 on a full match
        idx <= idx + 2'd1;
      end else if (cmd_data == MAGIC[31:24]) begin
        // a mismatching byte may itself be the start of a new key
        idx <= 2'd1;
      end else begin
        idx <= 2'd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Button synchronizer and debounce
  // ---------------------------------------------------------------------------
  logic            btn_meta;
  logic            btn_s;
  logic [DB_W-1:0] db_cnt;
  logic            btn_trig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b1;
      btn_s    <= 1'b1;
    end else begin
      btn_meta <= btn_n;
      btn_s    <= btn_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
    end else if (btn_s) begin
      db_cnt <= '0;
    end else if (db_cnt != DB_MAX) begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // Fires only on the DEBOUNCE_CYCLES-1 -> DEBOUNCE_CYCLES step, so a held
  // button (counter parked at DB_MAX) cannot retrigger.
  assign btn_trig = !btn_s && (db_cnt == DB_PRE);

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_run;
  logic             wdt_trig;

  assign wdt_run  = wdt_en && !wdt_kick;
  // A kick in the terminal cycle masks the trigger.
  assign wdt_trig = wdt_run && (wdt_cnt == WDT_TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt <= '0;
    end else if (!wdt_run) begin
      wdt_cnt <= '0;
    end else if (wdt_cnt != WDT_TERM) begin
      wdt_cnt <= wdt_cnt + WDT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  logic [1:0]       state;
  logic [DLY_W-1:0] dly_cnt;
  logic             any_trig;
  logic [1:0]       trig_cause;

  assign any_trig = cmd_trig || btn_trig || wdt_trig;

  // Coincident requests resolve command > button > watchdog.
  always_comb begin
    trig_cause = CAUSE_WDT;
    if (cmd_trig) begin
      trig_cause = CAUSE_CMD;
    end else if (btn_trig) begin
      trig_cause = CAUSE_BTN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      dly_cnt <= '0;
      reboot  <= 1'b1;
      pending <= 1'b0;
      cause   <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          reboot <= 1'b1;
          if (any_trig) begin
            state   <= ST_ARMED;
            dly_cnt <= DLY_LOAD;
            pending <= 1'b1;
            cause   <= trig_cause;
          end
        end
        ST_ARMED: begin
          // Loaded with DELAY_CYCLES-1, so reboot falls DELAY_CYCLES edges
          // after the trigger edge.
          if (dly_cnt != '0) begin
            dly_cnt <= dly_cnt - DLY_W'(1);
          end else begin
            state  <= ST_FIRE;
            reboot <= 1'b0;
          end
        end
        ST_FIRE: begin
          reboot  <= 1'b0;
          pending <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          reboot  <= 1'b1;
          pending <= 1'b0;
          cause   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reboot_trigger.sv
// tb/tb_reboot_trigger.sv - self-checking bench for reboot_trigger

module tb_reboot_trigger;

  localparam int          DEB   = 8;
  localparam int          WDT   = 20;
  localparam int          DLY   = 4;
  localparam logic [31:0] MAGIC = 32'h424F4F54;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       btn_n = 1'b1;
  logic       wdt_en = 1'b0;
  logic       wdt_kick = 1'b0;
  logic       reboot;
  logic       pending;
  logic [1:0] cause;

  int total = 0;
  int bad = 0;

  // Reference model state
  byte unsigned hist[$];
  bit  p1, p2;
  int  lowrun, run;
  bit  fired;
  int  t_edge, m_cause, edge_idx;

  reboot_trigger #(
    .MAGIC(MAGIC),
    .DEBOUNCE_CYCLES(DEB),
    .WDT_CYCLES(WDT),
    .DELAY_CYCLES(DLY)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_data(cmd_data),
    .btn_n(btn_n),
    .wdt_en(wdt_en),
    .wdt_kick(wdt_kick),
    .reboot(reboot),
    .pending(pending),
    .cause(cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === 32'(exp)) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    p1 = 1'b1;
    p2 = 1'b1;
    lowrun = 0;
    run = 0;
    fired = 1'b0;
    t_edge = 0;
    m_cause = 0;
    edge_idx = 0;
  endtask

  // One clock: drive inputs, predict, clock, compare all outputs.
  task automatic step(input bit v, input byte unsigned d, input bit b, input bit en, input bit k);
    bit tc, tb, tw;
    @(negedge clk);
    cmd_valid = v;
    cmd_data = d;
    btn_n = b;
    wdt_en = en;
    wdt_kick = k;
    // Command: the last four valid bytes since the previous match spell MAGIC.
    tc = 1'b0;
    if (v) begin
      hist.push_back(d);
      if (hist.size() > 4) void'(hist.pop_front());
      if (hist.size() == 4 && {hist[0], hist[1], hist[2], hist[3]} == MAGIC) begin
        tc = 1'b1;
        hist.delete();
      end
    end
    // Button: synchronized level has been low for exactly DEB-1 prior edges.
    tb = (p2 == 1'b0) && (lowrun == DEB - 1);
    // Watchdog: unserviced for at least WDT-1 prior edges and not kicked now.
    tw = en && !k && (run >= WDT - 1);
    if (!fired && (tc || tb || tw)) begin
      fired = 1'b1;
      t_edge = edge_idx;
      m_cause = tc ? 1 : (tb ? 2 : 3);
    end
    @(posedge clk);
    lowrun = p2 ? 0 : lowrun + 1;
    p2 = p1;
    p1 = b;
    run = (en && !k) ? run + 1 : 0;
    #1;
    chk("reboot", {31'b0, reboot}, (fired && (edge_idx - t_edge >= DLY)) ? 0 : 1);
    chk("pending", {31'b0, pending}, fired ? 1 : 0);
    chk("cause", {30'b0, cause}, m_cause);
    edge_idx++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic send(input byte unsigned b);
    idle($urandom_range(0, 3));
    step(1'b1, b, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    btn_n = 1'b1;
    wdt_en = 1'b0;
    wdt_kick = 1'b0;
    #1;
    chk("rst_reboot", {31'b0, reboot}, 1);
    chk("rst_pending", {31'b0, pending}, 0);
    chk("rst_cause", {30'b0, cause}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();

    // Reset state
    do_reset();
    idle(3);

    // Command with random gaps
    send(8'h42); send(8'h4F); send(8'h4F); send(8'h54);
    idle(8);
    chk("cmd_cause", {30'b0, cause}, 1);
    chk("cmd_reboot_low", {31'b0, reboot}, 0);

    // Restarted key
    do_reset();
    send(8'h42); send(8'h4F); send(8'h42); send(8'h4F); send(8'h4F); send(8'h54);
    idle(8);
    chk("restart_cause", {30'b0, cause}, 1);

    // Wrong last byte
    do_reset();
    send(8'h42); send(8'h4F); send(8'h4F); send(8'h55);
    idle(10);
    chk("badkey_reboot", {31'b0, reboot}, 1);
    chk("badkey_pending", {31'b0, pending}, 0);

    // Button held long enough
    do_reset();
    repeat (11) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(8);
    chk("btn_cause", {30'b0, cause}, 2);

    // Button too short, then glitches
    do_reset();
    repeat (7) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (6) begin
      repeat ($urandom_range(1, 4)) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      repeat ($urandom_range(1, 5)) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    idle(12);
    chk("glitch_pending", {31'b0, pending}, 0);

    // Button held 100 cycles
    do_reset();
    repeat (100) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("hold_cause", {30'b0, cause}, 2);

    // Watchdog serviced every 15 cycles, then starved
    do_reset();
    for (int i = 0; i < 60; i++) step(1'b0, 8'h00, 1'b1, 1'b1, (i % 15) == 0);
    chk("wdt_kicked_pending", {31'b0, pending}, 0);
    repeat (26) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("wdt_cause", {30'b0, cause}, 3);

    // Kick coincident with terminal count
    do_reset();
    repeat (19) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    idle(6);
    chk("wdt_edge_pending", {31'b0, pending}, 0);

    // All three sources in one cycle, then a press during ARMED
    do_reset();
    for (int c = 0; c < 32; c++) begin
      bit v;
      byte unsigned d;
      v = (c >= 16 && c <= 19);
      d = (c == 16) ? 8'h42 : (c == 19) ? 8'h54 : 8'h4F;
      step(v, v ? d : 8'h00, (c >= 10 && c < 20) || c >= 21 ? 1'b0 : 1'b1, 1'b1, 1'b0);
    end
    chk("simul_cause", {30'b0, cause}, 1);

    // Asynchronous reset while ARMED, then a fresh full delay
    do_reset();
    send(8'h42); send(8'h4F); send(8'h4F); send(8'h54);
    idle(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reboot", {31'b0, reboot}, 1);
    chk("async_pending", {31'b0, pending}, 0);
    chk("async_cause", {30'b0, cause}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    send(8'h42); send(8'h4F); send(8'h4F); send(8'h54);
    idle(8);

    // Random mixed traffic
    repeat (3) begin
      bit b;
      do_reset();
      b = 1'b1;
      for (int i = 0; i < 200; i++) begin
        bit v;
        byte unsigned d;
        int r;
        v = ($urandom_range(0, 2) == 0);
        r = $urandom_range(0, 3);
        d = (r == 0) ? 8'h42 : (r == 1) ? 8'h4F : (r == 2) ? 8'h54 : 8'($urandom_range(0, 255));
        if ($urandom_range(0, 9) == 0) b = ~b;
        step(v, d, b, ($urandom_range(0, 3) != 0), ($urandom_range(0, 30) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
